// File: rtl/conv_single_host.sv
// Host-side driver for the single-PE 3x3 convolution engine: loads a 4x4 image and a 3x3 filter
// from a byte stream, runs the engine until done (or timeout), then streams the 2x2 result out.
module conv_single_host #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [16*DATA_W-1:0] a_flat,
  output logic [9*DATA_W-1:0]  b_flat,
  output logic                 active_single,
  input  logic                 done_single,
  input  logic [DATA_W-1:0]    c11,
  input  logic [DATA_W-1:0]    c12,
  input  logic [DATA_W-1:0]    c21,
  input  logic [DATA_W-1:0]    c22,
  output logic                 busy,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {LOAD, RUN, SEND} state_t;

  localparam logic [5:0] CNT_TO = 6'(TIMEOUT);

  state_t            state;
  logic [5:0]        cnt;
  logic [DATA_W-1:0] c_reg [4];

  // Status outputs decode the state register only, so an async reset drops them immediately.
  assign in_ready      = (state == LOAD);
  assign active_single = (state == RUN);
  assign out_valid     = (state == SEND);
  assign busy          = (state != LOAD);
  assign out_last      = (state == SEND) && (cnt == 6'd3);
  assign out_data      = c_reg[cnt[1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      a_flat      <= '0;
      b_flat      <= '0;
      err_timeout <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) c_reg[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            err_timeout <= 1'b0;
            for (int unsigned i = 0; i < 16; i++)
              if (cnt == 6'(i)) a_flat[DATA_W*i +: DATA_W] <= in_data;
            for (int unsigned i = 0; i < 9; i++)
              if (cnt == 6'(16 + i)) b_flat[DATA_W*i +: DATA_W] <= in_data;
            if (cnt == 6'd24) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        RUN: begin
          if (done_single) begin
            c_reg[0] <= c11;
            c_reg[1] <= c12;
            c_reg[2] <= c21;
            c_reg[3] <= c22;
            state    <= SEND;
            cnt      <= '0;
          end else if (cnt == CNT_TO) begin
            err_timeout <= 1'b1;
            state       <= LOAD;
            cnt         <= '0;
            for (int unsigned i = 0; i < 4; i++) c_reg[i] <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (cnt == 6'd3) begin
              state <= LOAD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        default: begin
          state <= LOAD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_single_host.sv
// Self-checking bench for conv_single_host: a behavioural engine model answers active_single,
// and result streams are compared against table constants and an arithmetic convolution model.
module tb_conv_single_host;

  localparam int DW      = 8;
  localparam int TO      = 63;
  localparam int ENG_LAT = 37;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready = 1'b0;
  logic [16*DW-1:0] a_flat;
  logic [9*DW-1:0]  b_flat;
  logic            active_single;
  logic            done_single = 1'b0;
  logic [DW-1:0]   c11 = '0, c12 = '0, c21 = '0, c22 = '0;
  logic            busy;
  logic            err_timeout;

  int   passed = 0;
  int   total  = 0;
  logic eng_en = 1'b1;
  logic spur   = 1'b0;
  int   run_cyc = 0;
  logic [7:0] img [16];
  logic [7:0] filt [9];

  typedef struct {
    int          img_kind;
    int          filt_kind;
    int          gap;
    int          bp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  conv_single_host #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .a_flat(a_flat), .b_flat(b_flat), .active_single(active_single), .done_single(done_single),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Engine model: convolves whatever sits on a_flat/b_flat, pulses done ENG_LAT cycles into a run.
  function automatic logic [31:0] engine_calc();
    logic [31:0] r;
    int s;
    r = '0;
    for (int rr = 0; rr < 2; rr++)
      for (int cc = 0; cc < 2; cc++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(a_flat[8*((rr+i)*4+cc+j) +: 8]) * int'(b_flat[8*(i*3+j) +: 8]);
        r[31-8*(rr*2+cc) -: 8] = s[7:0];
      end
    return r;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (rst || !active_single) begin
      run_cyc     = 0;
      done_single = spur;
    end else begin
      run_cyc++;
      done_single = eng_en && (run_cyc == ENG_LAT);
    end
    if (done_single && active_single) {c11, c12, c21, c22} = engine_calc();
    else {c11, c12, c21, c22} = $urandom;
  end

  function automatic logic [31:0] conv_ref();
    logic [31:0] r;
    int s;
    r = '0;
    for (int rr = 0; rr < 2; rr++)
      for (int cc = 0; cc < 2; cc++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(img[(rr+i)*4+cc+j]) * int'(filt[i*3+j]);
        r[31-8*(rr*2+cc) -: 8] = s[7:0];
      end
    return r;
  endfunction

  function automatic logic [127:0] pack_a();
    logic [127:0] p;
    for (int i = 0; i < 16; i++) p[8*i +: 8] = img[i];
    return p;
  endfunction

  function automatic logic [71:0] pack_b();
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[8*i +: 8] = filt[i];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  task automatic set_data(input int ik, input int fk);
    for (int i = 0; i < 16; i++) img[i] = (ik == 0) ? 8'(i + 1) : 8'hFF;
    for (int i = 0; i < 9; i++)
      filt[i] = (fk == 0) ? 8'd1 : (fk == 1) ? ((i == 4) ? 8'd1 : 8'd0) : 8'd2;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_active"}, active_single, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_a_flat"}, a_flat, 0);
    chk({tag, "_b_flat"}, b_flat, 0);
  endtask

  // gap: 0 continuous, 1 every other cycle, 2 random
  task automatic load_bytes(input int gap);
    int   i = 0;
    int   k = 0;
    logic v;
    logic early = 1'b0;
    while (i < 25 && k < 500) begin
      @(negedge clk);
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (k % 2 == 0) : 1'($urandom % 2);
      in_valid = v;
      in_data  = (i < 16) ? img[i] : filt[i-16];
      if (active_single) early = 1'b1;
      if (v && in_ready) i++;
      k++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_count", i, 25);
    chk("no_early_active", early, 0);
    chk("active_after_load", active_single, 1);
    chk("a_flat_packing", a_flat, pack_a());
    chk("b_flat_packing", b_flat, pack_b());
  endtask

  // bp: 0 always ready, 1 five-cycle stall on byte 1, 2 random
  task automatic finish_pass(input int bp, input logic [31:0] exp);
    logic got = 1'b0, prev_done = 1'b0, lat_ok = 1'b0, act_drop = 1'b0, took_junk = 1'b0;
    logic [7:0] cap [4];
    logic       lst [4];
    int idx = 0, stall = 0, k = 0;
    for (int n = 0; n < TO + 8 && !got; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        lat_ok = prev_done;
        in_valid = 1'b0;
      end else begin
        if (!active_single) act_drop = 1'b1;
        if (in_ready) took_junk = 1'b1;
        prev_done = done_single;
        in_valid = 1'b1;
        in_data  = 8'hAA;
      end
    end
    in_valid = 1'b0;
    chk("reached_send", got, 1);
    chk("done_to_valid_1cyc", lat_ok, 1);
    chk("active_held_in_run", act_drop, 0);
    chk("no_ready_in_run", took_junk, 0);
    chk("active_off_in_send", active_single, 0);
    chk("busy_in_send", busy, 1);
    chk("a_flat_held", a_flat, pack_a());
    while (idx < 4 && k < 200) begin
      if (bp == 1 && idx == 1 && stall < 5) begin
        out_ready = 1'b0;
        chk("bp_hold_data", out_data, exp[23:16]);
        chk("bp_hold_valid", out_valid, 1);
        stall++;
      end else begin
        out_ready = (bp == 2) ? 1'($urandom % 2) : 1'b1;
      end
      if (out_valid && out_ready) begin
        cap[idx] = out_data;
        lst[idx] = out_last;
        idx++;
      end
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    chk("byte_count", idx, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_byte%0d", i), cap[i], exp[31-8*i -: 8]);
      chk($sformatf("out_last%0d", i), lst[i], (i == 3));
    end
    chk("back_to_load", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{img_kind: 0, filt_kind: 0, gap: 0, bp: 1, exp: 32'h363F5A63};
    vecs[1] = '{img_kind: 0, filt_kind: 0, gap: 1, bp: 0, exp: 32'h363F5A63};
    vecs[2] = '{img_kind: 0, filt_kind: 1, gap: 0, bp: 0, exp: 32'h06070A0B};
    vecs[3] = '{img_kind: 0, filt_kind: 2, gap: 1, bp: 2, exp: 32'h6C7EB4C6};
    vecs[4] = '{img_kind: 1, filt_kind: 0, gap: 2, bp: 0, exp: 32'hF7F7F7F7};

    @(negedge clk);
    reset_checks("por");
    @(negedge clk);
    rst = 1'b0;

    // done pulse while loading must be ignored
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("spur_done_busy", busy, 0);
    chk("spur_done_out_valid", out_valid, 0);

    for (int v = 0; v < 5; v++) begin
      set_data(vecs[v].img_kind, vecs[v].filt_kind);
      load_bytes(vecs[v].gap);
      finish_pass(vecs[v].bp, vecs[v].exp);
    end

    // asynchronous reset mid-cycle with loaded registers
    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_checks("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // timeout
    set_data(0, 0);
    eng_en = 1'b0;
    load_bytes(0);
    n = 0;
    while (active_single && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_run_cycles", n, TO + 1);
    chk("timeout_err", err_timeout, 1);
    chk("timeout_in_ready", in_ready, 1);
    chk("timeout_active", active_single, 0);
    chk("timeout_busy", busy, 0);
    eng_en = 1'b1;
    in_valid = 1'b1;
    in_data  = img[0];
    @(negedge clk);
    in_valid = 1'b0;
    chk("err_cleared_by_accept", err_timeout, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // reset at cycle 10 of RUN, then a normal pass
    load_bytes(0);
    repeat (10) @(negedge clk);
    chk("mid_run_active", active_single, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_checks("mid_run_rst");
    @(negedge clk);
    rst = 1'b0;
    load_bytes(0);
    finish_pass(0, 32'h363F5A63);

    // randomized passes against the arithmetic reference
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      for (int i = 0; i < 9; i++) filt[i] = 8'($urandom);
      load_bytes(2);
      finish_pass(2, conv_ref());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
